sw_debouncer: RTL and testbench
===============================

SW_DEBOUNCER -- requirements
Module: sw_debouncer

Interface
REQ-001 Parameter WIDTH, default 10, number of switch channels.
REQ-002 Parameter TICK_DIV, default 50000, clk cycles per sample tick; legal range is 1 or greater.
REQ-003 Parameter STABLE_TICKS, default 4, consecutive differing samples required to accept a new level; legal range is 1 or greater.
REQ-004 clk  input  1  system clock; all state SHALL be rising-edge clocked.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 sw_raw  input  WIDTH  asynchronous, bouncing slider inputs.
REQ-007 bypass  input  1  synchronous; when 1, debounce filtering SHALL be disabled.
REQ-008 sw_clean  output  WIDTH  registered, debounced level; drives the downstream PIO in_port.
REQ-009 sw_changed  output  WIDTH  registered, one-cycle pulse per channel on each sw_clean update.
REQ-010 tick  output  1  registered sample strobe, for observability.

Function
REQ-011 Each sw_raw bit SHALL pass through a 2-FF synchronizer (sync1, then sync2) before any other logic uses it.
REQ-012 Prescaler counter SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-013 tick SHALL be 1 for exactly the one cycle in which the prescaler equals TICK_DIV-1.
REQ-014 When TICK_DIV=1, tick SHALL be 1 every cycle.
REQ-015 The prescaler SHALL run regardless of bypass.
REQ-016 Each channel i SHALL have a counter cnt[i] of width clog2(STABLE_TICKS+1).
REQ-017 cnt[i] SHALL change only on cycles with tick=1.
REQ-018 On tick with sync2[i]==sw_clean[i]: cnt[i] SHALL go to 0.
REQ-019 On tick with sync2[i]!=sw_clean[i] and cnt[i]<STABLE_TICKS-1: cnt[i] SHALL increment by 1.
REQ-020 On tick with sync2[i]!=sw_clean[i] and cnt[i]==STABLE_TICKS-1: sw_clean[i] SHALL take sync2[i], cnt[i] SHALL go to 0, and sw_changed[i] SHALL be 1 in the same cycle sw_clean[i] first shows the new value.
REQ-021 sw_changed[i] SHALL be 0 in every other cycle; it SHALL never be high for 2 consecutive cycles when bypass=0.
REQ-022 Channels SHALL be independent; several channels qualifying on the same tick SHALL all update in that same cycle.
REQ-023 Latency with bypass=0 and a stable input: 2 synchronizer cycles plus STABLE_TICKS ticks (at most 2 + STABLE_TICKS*TICK_DIV cycles).
REQ-024 A bounce that is resampled equal to sw_clean on any tick SHALL restart qualification from cnt=0.
REQ-025 Activity between ticks SHALL be ignored.
REQ-026 bypass=1, every cycle: sw_clean SHALL load sync2, all cnt SHALL be held at 0, and sw_changed SHALL equal sync2 XOR the previous sw_clean.
REQ-027 A bypass 1->0 transition SHALL start qualification from cnt=0, with sw_clean keeping its current value.
REQ-028 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-029 reset_n=0 SHALL immediately clear sync1, sync2, the prescaler, all cnt, sw_clean, sw_changed and tick to 0.
REQ-030 After release, switches already high SHALL be accepted only after full qualification, producing one sw_changed pulse; a downstream edge capture therefore sees a rising edge on those channels.
REQ-031 Reset asserted mid-qualification SHALL discard partial counts; full STABLE_TICKS qualification is required again after release.

Verification (bench parameters: TICK_DIV=4, STABLE_TICKS=3, WIDTH=10)
REQ-032 Reset, then sw_raw=0 for 100 cycles -> sw_clean=0x000, sw_changed=0x000, tick high once every 4 cycles.
REQ-033 sw_raw[0] 0->1, held -> sw_clean[0]=1 on the 3rd tick after sync2[0]=1; sw_changed=0x001 for exactly 1 cycle.
REQ-034 sw_raw[1] high for 5 cycles, then low -> sw_clean[1] stays 0; no sw_changed[1] pulse.
REQ-035 sw_raw 0x000->0x3FF in one cycle -> all bits update in the same cycle; sw_changed=0x3FF for 1 cycle.
REQ-036 bypass=1 with sw_raw[2] toggled -> sw_clean[2] follows 3 cycles later; sw_changed[2] pulses on each toggle.
REQ-037 reset_n pulsed low while cnt[3]=2 -> all outputs 0; after release with sw_raw[3]=1, sw_clean[3]=1 only after 3 further ticks.

Source files
------------

// File: rtl/sw_debouncer.sv
// Purpose: 2-FF synchronise and debounce WIDTH slider switches, sampling on a prescaled tick.
// Latency: 2 sync cycles + STABLE_TICKS ticks (bypass: 3 cycles raw-to-clean), all outputs registered.
// Backpressure: none; free-running level filter, the downstream consumer samples sw_clean at will.
module sw_debouncer #(
   parameter int WIDTH        = 10,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             bypass,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_changed,
   output logic             tick
);

   // Prescaler width; TICK_DIV=1 still needs a 1-bit counter that stays at 0.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

   logic [WIDTH-1:0]          sync1_q, sync2_q;
   logic [PW-1:0]             presc_q, presc_d;
   logic                      tick_q, tick_d;
   logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]          clean_q, clean_d;
   logic [WIDTH-1:0]          changed_q, changed_d;

   // Two-stage synchronizer in front of everything else.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw_raw;
         sync2_q <= sync1_q;
      end
   end

   // Next prescaler value; tick is registered so it is high exactly while presc_q == TICK_DIV-1.
   always_comb begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      tick_d  = (presc_d == PRESC_LAST);
   end

   // Free-running prescaler, independent of bypass.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   // Per-channel qualification: a level is accepted after STABLE_TICKS consecutive
   // differing samples; any sample equal to the clean level restarts the count.
   // In bypass the synchronised input is passed straight through and counts stay cleared,
   // so leaving bypass always restarts qualification from zero.
   always_comb begin
      cnt_d     = cnt_q;
      clean_d   = clean_q;
      changed_d = '0;
      if (bypass) begin
         clean_d   = sync2_q;
         changed_d = sync2_q ^ clean_q;
         cnt_d     = '0;
      end else if (tick_q) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == clean_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               clean_d[i]   = sync2_q[i];
               changed_d[i] = 1'b1;
               cnt_d[i]     = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Filter state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         clean_q   <= '0;
         changed_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         clean_q   <= clean_d;
         changed_q <= changed_d;
      end
   end

   assign sw_clean   = clean_q;
   assign sw_changed = changed_q;
   assign tick       = tick_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with TICK_DIV=4, STABLE_TICKS=3, WIDTH=10.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Ends with a single summary line of check and failure counts.
module tb_sw_debouncer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       bypass;
   logic [9:0] sw_raw;
   logic [9:0] sw_clean;
   logic [9:0] sw_changed;
   logic       tick;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sw_debouncer #(
      .WIDTH        (10),
      .TICK_DIV     (4),
      .STABLE_TICKS (3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (sw_raw),
      .bypass     (bypass),
      .sw_clean   (sw_clean),
      .sw_changed (sw_changed),
      .tick       (tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Land just after the edge that ends a tick cycle; next filter updates are 4, 8, 12 edges later.
   task automatic sync_tick();
      int found;
      found = 0;
      for (int k = 0; k < 8 && found == 0; k++) begin
         adv(1);
         if (tick === 1'b1) found = 1;
      end
      chk("tick_sync", 32'(found), 32'd1);
      adv(1);
   endtask

   int tick_cnt;
   int bad_phase;
   int nz_out;
   int pulses;

   initial begin
      reset_n = 1'b0;
      sw_raw  = 10'h000;
      bypass  = 1'b0;
      #2;
      chk("rst_clean",   32'(sw_clean),   32'h000);
      chk("rst_changed", 32'(sw_changed), 32'h000);
      chk("rst_tick",    32'(tick),       32'h0);
      adv(2);
      reset_n = 1'b1;

      // Idle: 100 cycles, tick after edges 3,7,...,99
      tick_cnt = 0; bad_phase = 0; nz_out = 0;
      for (int i = 1; i <= 100; i++) begin
         adv(1);
         if (tick === 1'b1) tick_cnt++;
         if (tick !== ((i % 4) == 3)) bad_phase++;
         if (sw_clean !== 10'h000 || sw_changed !== 10'h000) nz_out++;
      end
      chk("idle_tick_count", 32'(tick_cnt),  32'd25);
      chk("idle_tick_phase", 32'(bad_phase), 32'd0);
      chk("idle_outputs",    32'(nz_out),    32'd0);

      // Channel 0 rising, accepted on the 12th edge after driving
      sync_tick();
      sw_raw = 10'h001;
      adv(11);
      chk("ch0_early_clean", 32'(sw_clean),   32'h000);
      adv(1);
      chk("ch0_clean",       32'(sw_clean),   32'h001);
      chk("ch0_pulse",       32'(sw_changed), 32'h001);
      adv(1);
      chk("ch0_pulse_end",   32'(sw_changed), 32'h000);
      chk("ch0_hold",        32'(sw_clean),   32'h001);

      // Channel 1 glitch of 5 cycles is rejected
      pulses = 0;
      sw_raw = 10'h003;
      for (int i = 0; i < 5; i++) begin
         adv(1);
         if (sw_changed[1] === 1'b1) pulses++;
      end
      sw_raw = 10'h001;
      for (int i = 0; i < 20; i++) begin
         adv(1);
         if (sw_changed[1] === 1'b1) pulses++;
      end
      chk("ch1_glitch_clean",  32'(sw_clean), 32'h001);
      chk("ch1_glitch_pulses", 32'(pulses),   32'd0);

      // Channel 4 bounce sampled low on the 3rd tick restarts qualification
      sync_tick();
      sw_raw = 10'h011;
      adv(9);
      sw_raw = 10'h001;
      adv(3);
      chk("ch4_bounce_clean", 32'(sw_clean), 32'h001);
      sw_raw = 10'h011;
      adv(11);
      chk("ch4_restart_early", 32'(sw_clean),   32'h001);
      adv(1);
      chk("ch4_clean",         32'(sw_clean),   32'h011);
      chk("ch4_pulse",         32'(sw_changed), 32'h010);

      // Return everything low
      sw_raw = 10'h000;
      adv(20);
      chk("clear_clean", 32'(sw_clean), 32'h000);

      // All channels at once
      sync_tick();
      sw_raw = 10'h3FF;
      adv(11);
      chk("all_early_clean", 32'(sw_clean),   32'h000);
      adv(1);
      chk("all_clean",       32'(sw_clean),   32'h3FF);
      chk("all_pulse",       32'(sw_changed), 32'h3FF);
      adv(1);
      chk("all_pulse_end",   32'(sw_changed), 32'h000);

      // Bypass: 3-cycle pass-through, pulse per toggle
      bypass = 1'b1;
      adv(3);
      chk("byp_steady_clean",   32'(sw_clean),   32'h3FF);
      chk("byp_steady_changed", 32'(sw_changed), 32'h000);
      sw_raw = 10'h3FB;
      adv(2);
      chk("byp_fall_lag",       32'(sw_clean),   32'h3FF);
      adv(1);
      chk("byp_fall_clean",     32'(sw_clean),   32'h3FB);
      chk("byp_fall_pulse",     32'(sw_changed), 32'h004);
      adv(1);
      chk("byp_fall_pulse_end", 32'(sw_changed), 32'h000);
      sw_raw = 10'h3FF;
      adv(3);
      chk("byp_rise_clean",     32'(sw_clean),   32'h3FF);
      chk("byp_rise_pulse",     32'(sw_changed), 32'h004);
      adv(1);
      chk("byp_rise_pulse_end", 32'(sw_changed), 32'h000);
      bypass = 1'b0;
      adv(2);
      chk("byp_exit_hold",      32'(sw_clean),   32'h3FF);

      // Reset while channel 3 has two qualifying samples
      sync_tick();
      sw_raw = 10'h3F7;
      adv(8);
      chk("pre_rst_clean", 32'(sw_clean), 32'h3FF);
      reset_n = 1'b0;
      sw_raw  = 10'h008;
      #1;
      chk("mid_rst_clean",   32'(sw_clean),   32'h000);
      chk("mid_rst_changed", 32'(sw_changed), 32'h000);
      chk("mid_rst_tick",    32'(tick),       32'h0);
      adv(2);
      reset_n = 1'b1;
      adv(11);
      chk("post_rst_early", 32'(sw_clean),   32'h000);
      adv(1);
      chk("post_rst_clean", 32'(sw_clean),   32'h008);
      chk("post_rst_pulse", 32'(sw_changed), 32'h008);
      adv(1);
      chk("post_rst_pulse_end", 32'(sw_changed), 32'h000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
